// File: rtl/tone_decoder_if.sv
// -----------------------------------------------------------------------------
// tone_decoder_if
// Bundles the tone input and the decoded-note outputs of tone_decoder.
//   i_tone   : raw (asynchronous) square-wave tone into the decoder
//   o_note   : decoded note code, 0 = silence/unknown, 1..11 = C_7..F_8
//   o_valid  : one-cycle strobe whenever o_note changes
//   o_period : last captured tone period in clk cycles
// Modports: master = tone source / observer, slave = decoder.
// -----------------------------------------------------------------------------
interface tone_decoder_if;
  logic        i_tone;
  logic [3:0]  o_note;
  logic        o_valid;
  logic [18:0] o_period;

  modport master (output i_tone, input o_note, input o_valid, input o_period);
  modport slave  (input i_tone, output o_note, output o_valid, output o_period);
endinterface

// File: rtl/tone_decoder.sv
// -----------------------------------------------------------------------------
// tone_decoder
// Measures the period of an incoming square-wave tone and decodes it into the
// melody player's 11-note set (C_7..F_8). A note is reported only after
// STABLE_CNT consecutive periods classify the same way; silence is declared
// when no rising edge arrives for TIMEOUT cycles.
// Ports:
//   clk      : system clock (50 MHz)
//   rst      : asynchronous, active-high reset
//   bus      : tone_decoder_if.slave
//              i_tone (in), o_note[3:0], o_valid, o_period[18:0] (out)
// Parameters:
//   TOL_SHIFT  : period P matches note N when |P-N| <= N >> TOL_SHIFT (>= 6)
//   STABLE_CNT : consecutive identical classifications before reporting (1..7)
//   TIMEOUT    : cycles without a rising edge that mean silence (> 191113)
// -----------------------------------------------------------------------------
module tone_decoder #(
  parameter int TOL_SHIFT  = 6,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 400000
) (
  input  logic          clk,
  input  logic          rst,
  tone_decoder_if.slave bus
);

  localparam int               CNT_W     = 19;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [2:0]       STABLE_V  = 3'(STABLE_CNT);

  typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

  // Full period of each note in clk cycles at 50 MHz.
  function automatic logic [CNT_W-1:0] note_period(input logic [3:0] code);
    logic [CNT_W-1:0] p;
    case (code)
      4'd1:    p = 19'd191113;
      4'd2:    p = 19'd170262;
      4'd3:    p = 19'd151686;
      4'd4:    p = 19'd143173;
      4'd5:    p = 19'd127553;
      4'd6:    p = 19'd113636;
      4'd7:    p = 19'd101238;
      4'd8:    p = 19'd95556;
      4'd9:    p = 19'd85131;
      4'd10:   p = 19'd75843;
      4'd11:   p = 19'd71586;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Lowest matching code wins: scanning downward lets lower codes overwrite.
  // The difference is formed larger-minus-smaller so it can never wrap.
  function automatic logic [3:0] classify(input logic [CNT_W-1:0] period);
    logic [3:0]       code;
    logic [CNT_W-1:0] n_p;
    logic [CNT_W-1:0] diff;
    code = 4'd0;
    for (int k = 11; k >= 1; k--) begin
      n_p  = note_period(4'(k));
      diff = (period >= n_p) ? (period - n_p) : (n_p - period);
      if (diff <= (n_p >> TOL_SHIFT)) code = 4'(k);
    end
    return code;
  endfunction

  logic             r_sync0, r_sync1, r_sync2;
  logic             w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_period;
  logic             w_timeout;
  state_t           r_state, w_state_nxt;
  logic             w_capture;
  logic             w_meas_timeout;
  logic [CNT_W-1:0] r_period_p1;
  logic [3:0]       r_class_p1;
  logic             r_vld_p1;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [2:0]       r_match, w_match_nxt;
  logic [3:0]       r_note;
  logic             r_valid;

  // ---- stage p0: synchronizer, edge detect, period counter ----
  assign w_edge    = r_sync1 & ~r_sync2;
  // The counter is cleared on the edge cycle itself, so it reads P-1 when the
  // next edge arrives; the +1 restores the true edge-to-edge distance.
  assign w_period  = r_cnt + 19'd1;
  assign w_timeout = (r_cnt == TIMEOUT_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= bus.i_tone;
      r_sync1 <= r_sync0;
      r_sync2 <= r_sync1;
      if (w_edge)
        r_cnt <= '0;
      else if (r_cnt != TIMEOUT_V)
        r_cnt <= r_cnt + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // An edge always beats a timeout landing in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_meas_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_edge) begin
          w_capture = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt    = ST_IDLE;
          w_meas_timeout = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p1: captured period and its registered classification ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= w_capture;
      if (w_capture) r_period_p1 <= w_period;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_class_p1 <= classify(w_period);
  end

  always_comb begin
    w_cand_nxt  = r_class_p1;
    w_match_nxt = 3'd1;
    if (r_class_p1 == r_cand) begin
      w_cand_nxt  = r_cand;
      w_match_nxt = (r_match >= STABLE_V) ? STABLE_V : (r_match + 3'd1);
    end
  end

  // ---- stage p2: match tracking, reported note and strobe ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand  <= 4'd0;
      r_match <= 3'd0;
      r_note  <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_meas_timeout) begin
        r_cand  <= 4'd0;
        r_match <= 3'd0;
        if (r_note != 4'd0) begin
          r_note  <= 4'd0;
          r_valid <= 1'b1;
        end
      end else if (r_vld_p1) begin
        r_cand  <= w_cand_nxt;
        r_match <= w_match_nxt;
        if ((w_match_nxt == STABLE_V) && (w_cand_nxt != r_note)) begin
          r_note  <= w_cand_nxt;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.o_note   = r_note;
  assign bus.o_valid  = r_valid;
  assign bus.o_period = r_period_p1;

endmodule

// File: tb/tb_tone_decoder.sv
// -----------------------------------------------------------------------------
// tb_tone_decoder
// Directed bench for tone_decoder: drives exact square-wave periods and checks
// the decoded note, strobe count/timing and captured period against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_tone_decoder;

  localparam int TIMEOUT = 400000;

  logic clk = 1'b0;
  logic rst;

  tone_decoder_if bus();

  tone_decoder #(
    .TOL_SHIFT  (6),
    .STABLE_CNT (3),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int         cyc = 0;
  int         n_pulse = 0;
  int         last_pulse_cyc = -1;
  logic [3:0] last_pulse_note = 4'd0;
  int         n_b2b = 0;
  logic       prev_valid = 1'b0;
  int         last_rise = 0;
  int         vectors = 0;
  int         miscompares = 0;

  // Cycle counter and strobe monitor; outputs sampled 1 ns after each edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.o_valid === 1'b1) begin
        n_pulse++;
        last_pulse_cyc  = cyc;
        last_pulse_note = bus.o_note;
        if (prev_valid === 1'b1) n_b2b++;
      end
      prev_valid = bus.o_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One full tone period starting with a rising edge; entered and left on a
  // falling clk edge so consecutive rising edges are exactly p cycles apart.
  task automatic tone_cycle(input int p);
    bus.i_tone = 1'b1;
    last_rise  = cyc;
    repeat (p / 2) @(negedge clk);
    bus.i_tone = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  // A rise driven when cyc==R is sampled at edge R+1, E is seen at edge R+3,
  // and o_note/o_valid change at edge R+4.
  localparam int VALID_LAT = 4;

  initial begin
    int base;
    rst        = 1'b1;
    bus.i_tone = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_note",   bus.o_note,   0);
    chk("rst_valid",  bus.o_valid,  0);
    chk("rst_period", bus.o_period, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // B_7: lock on the 3rd captured period (4th rising edge)
    base = n_pulse;
    repeat (3) tone_cycle(101238);
    chk("b7_before_lock_note", bus.o_note, 0);
    chk("b7_before_lock_pulses", n_pulse - base, 0);
    tone_cycle(101238);
    chk("b7_lock_note", bus.o_note, 7);
    chk("b7_lock_pulses", n_pulse - base, 1);
    chk("b7_lock_latency", last_pulse_cyc - last_rise, VALID_LAT);
    chk("b7_pulse_note", last_pulse_note, 7);
    tone_cycle(101238);
    chk("b7_period", bus.o_period, 101238);
    chk("b7_single_pulse", n_pulse - base, 1);

    // Switch to D_8
    base = n_pulse;
    repeat (3) tone_cycle(85131);
    chk("d8_hold7_note", bus.o_note, 7);
    chk("d8_hold7_pulses", n_pulse - base, 0);
    tone_cycle(85131);
    chk("d8_note", bus.o_note, 9);
    chk("d8_pulses", n_pulse - base, 1);
    chk("d8_latency", last_pulse_cyc - last_rise, VALID_LAT);
    chk("d8_period", bus.o_period, 85131);

    // 98000 falls between B_7 and C_8 windows -> unknown
    base = n_pulse;
    repeat (4) tone_cycle(98000);
    chk("gap_note", bus.o_note, 0);
    chk("gap_pulses", n_pulse - base, 1);
    chk("gap_pulse_note", last_pulse_note, 0);
    chk("gap_period", bus.o_period, 98000);

    // Upper tolerance edge of B_7: 101238 + (101238>>6) = 102819
    base = n_pulse;
    repeat (4) tone_cycle(102819);
    chk("tol_in_note", bus.o_note, 7);
    chk("tol_in_pulses", n_pulse - base, 1);
    chk("tol_in_period", bus.o_period, 102819);

    // Reset while locked with the tone high
    bus.i_tone = 1'b1;
    last_rise  = cyc;
    repeat (1000) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_note",   bus.o_note,   0);
    chk("midrst_valid",  bus.o_valid,  0);
    chk("midrst_period", bus.o_period, 0);
    repeat (3) @(negedge clk);
    // Releasing with the tone high behaves like a rise at this instant.
    rst  = 1'b0;
    base = n_pulse;
    repeat (50000) @(negedge clk);
    bus.i_tone = 1'b0;
    repeat (101238 - 50000) @(negedge clk);
    repeat (2) tone_cycle(101238);
    chk("relock_early_note", bus.o_note, 0);
    chk("relock_early_pulses", n_pulse - base, 0);
    tone_cycle(101238);
    chk("relock_note", bus.o_note, 7);
    chk("relock_pulses", n_pulse - base, 1);

    // One cycle beyond the tolerance edge -> unknown
    base = n_pulse;
    repeat (4) tone_cycle(102820);
    chk("tol_out_note", bus.o_note, 0);
    chk("tol_out_pulses", n_pulse - base, 1);
    chk("tol_out_period", bus.o_period, 102820);

    // Lock on G_7, then go silent
    base = n_pulse;
    repeat (4) tone_cycle(127553);
    chk("g7_note", bus.o_note, 5);
    chk("g7_pulses", n_pulse - base, 1);
    base = n_pulse;
    repeat (TIMEOUT - 127553 + 10) @(negedge clk);
    chk("silence_note", bus.o_note, 0);
    chk("silence_pulses", n_pulse - base, 1);
    chk("silence_latency", last_pulse_cyc - last_rise, TIMEOUT + VALID_LAT);
    repeat (2000) @(negedge clk);
    chk("silence_no_repeat", n_pulse - base, 1);

    // Alternating F_8 / E_8 never settles
    base = n_pulse;
    tone_cycle(71586);
    tone_cycle(75843);
    tone_cycle(71586);
    tone_cycle(75843);
    tone_cycle(71586);
    chk("alt_note", bus.o_note, 0);
    chk("alt_pulses", n_pulse - base, 0);
    chk("alt_period", bus.o_period, 75843);

    chk("valid_back_to_back", n_b2b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
